// File: rtl/pe_operand_feeder_pkg.sv
// Shared types and default sizing for the pe operand feeder slice.
package pe_feed_pkg;

    localparam int DEF_DW     = 16;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_PE_LAT = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } feed_state_e;

endpackage

// File: rtl/pe_operand_feeder_if.sv
// Lane bus to the pe tile plus the dot-product result handshake.
interface pe_operand_feeder_if
    import pe_feed_pkg::*;
#(
    parameter int DW = DEF_DW
);
    logic [DW-1:0] ifm_0, ifm_1, ifm_2, ifm_3;
    logic [DW-1:0] w_0, w_1, w_2, w_3;
    logic [DW-1:0] pe_result;

    // dot_valid/dot_ready: a transfer happens on an edge where both are high;
    // dot is stable while dot_valid is high and dot_valid never waits on dot_ready.
    logic [DW-1:0] dot;
    logic          dot_valid;
    logic          dot_ready;

    modport master (
        output ifm_0, ifm_1, ifm_2, ifm_3, w_0, w_1, w_2, w_3, dot, dot_valid,
        input  pe_result, dot_ready
    );

    modport slave (
        input  ifm_0, ifm_1, ifm_2, ifm_3, w_0, w_1, w_2, w_3, dot, dot_valid,
        output pe_result, dot_ready
    );
endinterface

// File: rtl/pe_operand_buf.sv
// Ifm and weight buffers: one write port, registered 4-word read by group index.
module pe_operand_buf
    import pe_feed_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int GW    = $clog2(DEPTH / 4) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic                 rd_en,
    input  logic [GW-1:0]        rd_group,
    output logic [3:0][DW-1:0]   ifm_q,
    output logic [3:0][DW-1:0]   wt_q
);
    logic [DW-1:0] ifm_mem [DEPTH];
    logic [DW-1:0] wt_mem  [DEPTH];
    logic [AW-1:0] base;

    assign base = AW'({rd_group, 2'b00});

    // Storage survives reset so a run can be repeated without reloading.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_sel) wt_mem[wr_addr]  <= wr_data;
            else        ifm_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifm_q <= '0;
            wt_q  <= '0;
        end else if (rd_en) begin
            for (int k = 0; k < 4; k++) begin
                ifm_q[k] <= ifm_mem[base + AW'(k)];
                wt_q[k]  <= wt_mem[base + AW'(k)];
            end
        end else begin
            ifm_q <= '0;
            wt_q  <= '0;
        end
    end
endmodule

// File: rtl/pe_operand_feeder.sv
// Streams buffered ifm/weight groups into pe and accumulates its results into one dot product.
module pe_operand_feeder
    import pe_feed_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int PE_LAT = DEF_PE_LAT,
    parameter int AW     = $clog2(DEPTH),
    parameter int GW     = $clog2(DEPTH / 4) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [AW-1:0]           wr_addr,
    input  logic [DW-1:0]           wr_data,
    input  logic                    start,
    input  logic [GW-1:0]           len,
    output logic                    busy,
    output logic                    err,
    pe_operand_feeder_if.master     pe_if,
    output feed_state_e             state_dbg
);
    localparam logic [1:0] IDLE  = S_IDLE;
    localparam logic [1:0] ISSUE = S_ISSUE;
    localparam logic [1:0] DRAIN = S_DRAIN;
    localparam logic [1:0] DONE  = S_DONE;

    logic [1:0]          state, state_d;
    logic [GW-1:0]       g, len_q;
    logic [PE_LAT:0]     tags;
    logic [DW-1:0]       acc;
    logic                len_ok, launch;
    logic [3:0][DW-1:0]  ifm_lane, wt_lane;

    assign len_ok = (len != '0) && (len <= GW'(DEPTH / 4));
    assign launch = (state == IDLE) && start && len_ok;

    pe_operand_buf #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .GW(GW)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en && (state == IDLE)),
        .wr_sel   (wr_sel),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (state == ISSUE),
        .rd_group (g),
        .ifm_q    (ifm_lane),
        .wt_q     (wt_lane)
    );

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (launch) state_d = ISSUE;
            ISSUE:   if (g == len_q - GW'(1)) state_d = DRAIN;
            // Only the final stage may still hold a tag; it is consumed on this edge.
            DRAIN:   if (tags[PE_LAT-1:0] == '0) state_d = DONE;
            DONE:    if (pe_if.dot_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The tag chain is one stage longer than PE_LAT because the lane outputs
    // themselves add a register ahead of the pe pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            g         <= '0;
            len_q     <= '0;
            tags      <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            pe_if.dot_valid <= 1'b0;
        end else begin
            state     <= state_d;
            busy      <= (state_d != IDLE);
            pe_if.dot_valid <= (state_d == DONE);
            err       <= (state == IDLE) && start && !len_ok;
            tags      <= {tags[PE_LAT-1:0], state == ISSUE};
            if (launch) begin
                acc   <= '0;
                g     <= '0;
                len_q <= len;
            end else begin
                if (tags[PE_LAT]) acc <= acc + pe_if.pe_result;
                if (state == ISSUE) g <= g + GW'(1);
            end
        end
    end

    assign pe_if.dot   = acc;
    assign pe_if.ifm_0 = ifm_lane[0];
    assign pe_if.ifm_1 = ifm_lane[1];
    assign pe_if.ifm_2 = ifm_lane[2];
    assign pe_if.ifm_3 = ifm_lane[3];
    assign pe_if.w_0   = wt_lane[0];
    assign pe_if.w_1   = wt_lane[1];
    assign pe_if.w_2   = wt_lane[2];
    assign pe_if.w_3   = wt_lane[3];
    assign state_dbg   = feed_state_e'(state);
endmodule
